// File: rtl/lane_dly_pkg.sv
// Shared definitions for the lane delay-line sequencer: request opcodes,
// FSM state encoding, tap-tracker operations and legal parameter ranges.
package lane_dly_pkg;

    // Request opcodes; 2'b10 and 2'b11 are reserved and complete with ERR.
    localparam logic [1:0] OP_MOVE = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;

    // Legal parameter ranges.
    localparam int MOVE_GAP_MIN    = 2;
    localparam int MOVE_GAP_MAX    = 15;
    localparam int LOAD_SETTLE_MIN = 1;
    localparam int LOAD_SETTLE_MAX = 255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_LOAD,
        ST_SETTLE,
        ST_FIN
    } state_e;

    // Operation applied to the selected tap register in a given cycle.
    typedef enum logic [1:0] {
        TAP_HOLD,
        TAP_STEP,
        TAP_LOAD
    } tap_op_e;

endpackage

// File: rtl/lane_dly_tap_trk.sv
// Tracks the RX and TX DQS delay-line tap positions.
// Ports:
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   op_i                hold / saturating step / load to INIT_TAP
//   sel_i               0 = RX line, 1 = TX line
//   dir_i               step direction, 1 = increment
//   rx_tap_o, tx_tap_o  tracked tap positions
//   sat_o               selected line already at its limit in direction dir_i
module lane_dly_tap_trk
    import lane_dly_pkg::*;
#(
    parameter int TAP_W    = 8,
    parameter int INIT_TAP = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  tap_op_e          op_i,
    input  logic             sel_i,
    input  logic             dir_i,
    output logic [TAP_W-1:0] rx_tap_o,
    output logic [TAP_W-1:0] tx_tap_o,
    output logic             sat_o
);

    localparam logic [TAP_W-1:0] INIT_VAL = TAP_W'(INIT_TAP);
    localparam logic [TAP_W-1:0] TAP_MAX  = '1;

    logic [TAP_W-1:0] rx_tap_q, tx_tap_q;
    logic [TAP_W-1:0] sel_tap;
    logic [TAP_W-1:0] step_tap_d;

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sel_tap    = sel_i ? tx_tap_q : rx_tap_q;
        sat_o      = dir_i ? (sel_tap == TAP_MAX) : (sel_tap == '0);
        step_tap_d = sel_tap;
        if (!sat_o) begin
            step_tap_d = dir_i ? sel_tap + 1'b1 : sel_tap - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rx_tap_q <= INIT_VAL;
            tx_tap_q <= INIT_VAL;
        end else begin
            unique case (op_i)
                TAP_STEP: begin
                    if (sel_i) tx_tap_q <= step_tap_d;
                    else       rx_tap_q <= step_tap_d;
                end
                TAP_LOAD: begin
                    if (sel_i) tx_tap_q <= INIT_VAL;
                    else       rx_tap_q <= INIT_VAL;
                end
                default: ;
            endcase
        end
    end

    assign rx_tap_o = rx_tap_q;
    assign tx_tap_o = tx_tap_q;

endmodule

// File: rtl/lane_dly_seq.sv
// Sequences MOVE and LOAD requests onto a lane controller's DQS delay-line
// port, tracking tap positions and reporting completion status.
// Ports:
//   fab_clk_i, reset_n_i            clock, synchronous active-low reset
//   req_valid_i / req_ready_o       request handshake
//   req_op_i, req_sel_i, req_dir_i, req_count_i   request fields
//   done_o, err_o, moved_o          completion pulse, error pulse, taps moved
//   rx_tap_o, tx_tap_o              tracked tap positions
//   delay_line_*_o                  delay-line control port
//   *_delay_line_out_of_range_i     range flags from the lane controller
module lane_dly_seq
    import lane_dly_pkg::*;
#(
    parameter int TAP_W       = 8,
    parameter int MOVE_GAP    = 4,
    parameter int LOAD_SETTLE = 8,
    parameter int INIT_TAP    = 1
) (
    input  logic             fab_clk_i,
    input  logic             reset_n_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_op_i,
    input  logic             req_sel_i,
    input  logic             req_dir_i,
    input  logic [TAP_W-1:0] req_count_i,
    output logic             done_o,
    output logic             err_o,
    output logic [TAP_W-1:0] moved_o,
    output logic [TAP_W-1:0] rx_tap_o,
    output logic [TAP_W-1:0] tx_tap_o,
    output logic             delay_line_sel_o,
    output logic             delay_line_direction_o,
    output logic             delay_line_load_o,
    output logic             delay_line_move_o,
    input  logic             rx_delay_line_out_of_range_i,
    input  logic             tx_delay_line_out_of_range_i
);

    if (MOVE_GAP < MOVE_GAP_MIN || MOVE_GAP > MOVE_GAP_MAX) begin : g_bad_gap
        $error("lane_dly_seq: MOVE_GAP out of range");
    end
    if (LOAD_SETTLE < LOAD_SETTLE_MIN || LOAD_SETTLE > LOAD_SETTLE_MAX) begin : g_bad_settle
        $error("lane_dly_seq: LOAD_SETTLE out of range");
    end

    state_e           state_q;
    logic             sel_q, dir_q;
    logic [TAP_W-1:0] count_q, moved_cnt_q;
    logic [3:0]       gap_cnt_q;
    logic [7:0]       settle_cnt_q;
    logic             ready_q, done_q, err_q;
    logic [TAP_W-1:0] moved_q;
    logic             dl_sel_q, dl_dir_q, dl_load_q, dl_move_q;

    tap_op_e          tap_op_d;
    logic             tap_sat;
    logic             oor_sel;

    always_comb begin
        tap_op_d = TAP_HOLD;
        if (state_q == ST_PULSE)     tap_op_d = TAP_STEP;
        else if (state_q == ST_LOAD) tap_op_d = TAP_LOAD;
    end

    // Only the selected line's range flag can abort a move.
    assign oor_sel = sel_q ? tx_delay_line_out_of_range_i
                           : rx_delay_line_out_of_range_i;

    lane_dly_tap_trk #(
        .TAP_W    (TAP_W),
        .INIT_TAP (INIT_TAP)
    ) u_tap_trk (
        .clk_i    (fab_clk_i),
        .rst_n_i  (reset_n_i),
        .op_i     (tap_op_d),
        .sel_i    (sel_q),
        .dir_i    (dir_q),
        .rx_tap_o (rx_tap_o),
        .tx_tap_o (tx_tap_o),
        .sat_o    (tap_sat)
    );

    // Outputs are registered: each is set on the edge that enters the state
    // in which it must be visible.
    always_ff @(posedge fab_clk_i) begin
        if (!reset_n_i) begin
            state_q      <= ST_IDLE;
            sel_q        <= 1'b0;
            dir_q        <= 1'b0;
            count_q      <= '0;
            moved_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            settle_cnt_q <= '0;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            moved_q      <= '0;
            dl_sel_q     <= 1'b0;
            dl_dir_q     <= 1'b0;
            dl_load_q    <= 1'b0;
            dl_move_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            dl_move_q <= 1'b0;
            dl_load_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        sel_q       <= req_sel_i;
                        dir_q       <= req_dir_i;
                        count_q     <= req_count_i;
                        moved_cnt_q <= '0;
                        ready_q     <= 1'b0;
                        if (req_op_i == OP_MOVE && req_count_i != '0) begin
                            state_q  <= ST_SETUP;
                            dl_sel_q <= req_sel_i;
                            dl_dir_q <= req_dir_i;
                        end else if (req_op_i == OP_LOAD) begin
                            state_q   <= ST_LOAD;
                            dl_load_q <= 1'b1;
                            dl_sel_q  <= req_sel_i;
                        end else begin
                            // Zero-count MOVE or reserved opcode.
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                            err_q   <= (req_op_i != OP_MOVE);
                            moved_q <= '0;
                        end
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_PULSE;
                    dl_move_q <= 1'b1;
                end
                ST_PULSE: begin
                    state_q     <= ST_GAP;
                    moved_cnt_q <= moved_cnt_q + 1'b1;
                    gap_cnt_q   <= 4'(MOVE_GAP - 2);
                end
                ST_GAP: begin
                    if (gap_cnt_q != '0) begin
                        gap_cnt_q <= gap_cnt_q - 1'b1;
                    end else if (oor_sel || tap_sat || moved_cnt_q == count_q) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                        err_q   <= oor_sel || tap_sat;
                        moved_q <= moved_cnt_q;
                    end else begin
                        state_q   <= ST_PULSE;
                        dl_move_q <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    state_q      <= ST_SETTLE;
                    settle_cnt_q <= 8'(LOAD_SETTLE - 1);
                end
                ST_SETTLE: begin
                    if (settle_cnt_q != '0) begin
                        settle_cnt_q <= settle_cnt_q - 1'b1;
                    end else begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                        moved_q <= '0;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready_o            = ready_q;
    assign done_o                 = done_q;
    assign err_o                  = err_q;
    assign moved_o                = moved_q;
    assign delay_line_sel_o       = dl_sel_q;
    assign delay_line_direction_o = dl_dir_q;
    assign delay_line_load_o      = dl_load_q;
    assign delay_line_move_o      = dl_move_q;

endmodule

// File: tb/tb_lane_dly_seq.sv
// Self-checking bench for lane_dly_seq: a table of requests with expected
// latency, status, pulse counts and resulting taps, plus a directed
// mid-operation reset sequence.
module tb_lane_dly_seq;
    import lane_dly_pkg::*;

    localparam int TAP_W       = 8;
    localparam int MOVE_GAP    = 4;
    localparam int LOAD_SETTLE = 8;
    localparam int INIT_TAP    = 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic             req_sel;
    logic             req_dir;
    logic [TAP_W-1:0] req_count;
    logic             done, err;
    logic [TAP_W-1:0] moved, rx_tap, tx_tap;
    logic             dl_sel, dl_dir, dl_load, dl_move;
    logic             rx_oor, tx_oor;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lane_dly_seq #(
        .TAP_W       (TAP_W),
        .MOVE_GAP    (MOVE_GAP),
        .LOAD_SETTLE (LOAD_SETTLE),
        .INIT_TAP    (INIT_TAP)
    ) dut (
        .fab_clk_i                    (clk),
        .reset_n_i                    (reset_n),
        .req_valid_i                  (req_valid),
        .req_ready_o                  (req_ready),
        .req_op_i                     (req_op),
        .req_sel_i                    (req_sel),
        .req_dir_i                    (req_dir),
        .req_count_i                  (req_count),
        .done_o                       (done),
        .err_o                        (err),
        .moved_o                      (moved),
        .rx_tap_o                     (rx_tap),
        .tx_tap_o                     (tx_tap),
        .delay_line_sel_o             (dl_sel),
        .delay_line_direction_o       (dl_dir),
        .delay_line_load_o            (dl_load),
        .delay_line_move_o            (dl_move),
        .rx_delay_line_out_of_range_i (rx_oor),
        .tx_delay_line_out_of_range_i (tx_oor)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]       op;
        logic             sel;
        logic             dir;
        logic [TAP_W-1:0] count;
        int               oor_after; // raise RX range flag after this many pulses (0 = never)
        int               lat;       // cycles from acceptance to DONE
        logic             err;
        logic [TAP_W-1:0] moved;
        int               n_move;
        int               n_load;
        logic [TAP_W-1:0] rx;
        logic [TAP_W-1:0] tx;
    } vec_t;

    vec_t vecs[10];

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, req_ready, 1);
        check({tag, "_done"},  done, 0);
        check({tag, "_err"},   err, 0);
        check({tag, "_moved"}, moved, 0);
        check({tag, "_rx"},    rx_tap, INIT_TAP);
        check({tag, "_tx"},    tx_tap, INIT_TAP);
        check({tag, "_dlsel"}, dl_sel, 0);
        check({tag, "_dldir"}, dl_dir, 0);
        check({tag, "_dlld"},  dl_load, 0);
        check({tag, "_dlmv"},  dl_move, 0);
    endtask

    // Called on a negedge with the DUT idle; returns on the negedge of the
    // cycle after DONE so the next request is issued back-to-back.
    task automatic run_req(input vec_t v);
        int  prev;
        int  n_mv;
        int  n_ld;
        bit  seen;
        check("ready_before", req_ready, 1);
        req_valid = 1'b1;
        req_op    = v.op;
        req_sel   = v.sel;
        req_dir   = v.dir;
        req_count = v.count;
        @(posedge clk);
        @(negedge clk);
        // Scramble the request fields: they must have been latched.
        req_valid = 1'b0;
        req_sel   = ~v.sel;
        req_dir   = ~v.dir;
        req_count = ~v.count;
        prev = -1;
        n_mv = 0;
        n_ld = 0;
        seen = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            // The unselected line's flag toggles and must be ignored.
            if (v.sel) rx_oor = ~rx_oor;
            else       tx_oor = ~tx_oor;
            if (dl_move) begin
                n_mv++;
                check("move_sel", dl_sel, v.sel);
                check("move_dir", dl_dir, v.dir);
                if (prev < 0) check("first_pulse_cycle", k, 2);
                else          check("pulse_spacing", k - prev, MOVE_GAP);
                prev = k;
                if (n_mv == v.oor_after) rx_oor = 1'b1;
            end
            if (dl_load) begin
                n_ld++;
                check("load_sel", dl_sel, v.sel);
            end
            if (done) begin
                seen = 1'b1;
                check("done_latency", k, v.lat);
                check("err", err, v.err);
                check("moved", moved, v.moved);
                check("ready_in_fin", req_ready, 0);
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("done_seen", seen, 1);
        check("move_pulses", n_mv, v.n_move);
        check("load_pulses", n_ld, v.n_load);
        @(posedge clk);
        @(negedge clk);
        rx_oor = 1'b0;
        tx_oor = 1'b0;
        check("done_one_cycle", done, 0);
        check("err_one_cycle", err, 0);
        check("moved_held", moved, v.moved);
        check("rx_tap", rx_tap, v.rx);
        check("tx_tap", tx_tap, v.tx);
    endtask

    initial begin
        int dn;
        //          op     sel   dir   cnt oor lat err mv nm nl rx tx
        vecs[0] = '{OP_MOVE, 1'b0, 1'b1, 8'd3,  0, 14, 1'b0, 8'd3, 3, 0, 8'd4, 8'd1};
        vecs[1] = '{OP_MOVE, 1'b1, 1'b1, 8'd8,  0, 34, 1'b0, 8'd8, 8, 0, 8'd4, 8'd9};
        vecs[2] = '{OP_LOAD, 1'b1, 1'b0, 8'd0,  0, 10, 1'b0, 8'd0, 0, 1, 8'd4, 8'd1};
        vecs[3] = '{OP_MOVE, 1'b1, 1'b0, 8'd5,  0,  6, 1'b1, 8'd1, 1, 0, 8'd4, 8'd0};
        vecs[4] = '{2'b11,   1'b0, 1'b1, 8'd4,  0,  1, 1'b1, 8'd0, 0, 0, 8'd4, 8'd0};
        vecs[5] = '{OP_MOVE, 1'b0, 1'b1, 8'd0,  0,  1, 1'b0, 8'd0, 0, 0, 8'd4, 8'd0};
        vecs[6] = '{2'b10,   1'b1, 1'b0, 8'd2,  0,  1, 1'b1, 8'd0, 0, 0, 8'd4, 8'd0};
        vecs[7] = '{OP_MOVE, 1'b0, 1'b0, 8'd2,  0, 10, 1'b0, 8'd2, 2, 0, 8'd2, 8'd0};
        vecs[8] = '{OP_LOAD, 1'b0, 1'b1, 8'd7,  0, 10, 1'b0, 8'd0, 0, 1, 8'd1, 8'd0};
        vecs[9] = '{OP_MOVE, 1'b0, 1'b1, 8'd10, 2, 10, 1'b1, 8'd2, 2, 0, 8'd3, 8'd0};

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_MOVE;
        req_sel   = 1'b0;
        req_dir   = 1'b0;
        req_count = '0;
        rx_oor    = 1'b0;
        tx_oor    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_req(vecs[i]);
        end

        // Reset for one cycle inside a GAP of a COUNT=6 move.
        req_valid = 1'b1;
        req_op    = OP_MOVE;
        req_sel   = 1'b0;
        req_dir   = 1'b1;
        req_count = 8'd6;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rst_pre_tap_moved", rx_tap, 4);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_reset_outputs("midrst");
        dn = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || dl_move) dn++;
        end
        check("midrst_no_activity", dn, 0);
        check("midrst_ready", req_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_dly_seq.md
LANE_DLY_SEQ -- requirements
Module: lane_dly_seq

Interface
REQ-001 Parameter TAP_W, default 8: width of tap counts and tracked tap positions.
REQ-002 Parameter MOVE_GAP, default 4: FAB_CLK cycles from one DELAY_LINE_MOVE pulse to the next; legal range 2..15.
REQ-003 Parameter LOAD_SETTLE, default 8: cycles to hold after a DELAY_LINE_LOAD pulse before completion; legal range 1..255.
REQ-004 Parameter INIT_TAP, default 1: tap value the lane's delay lines take on LOAD and on reset.
REQ-005 FAB_CLK  in  1  sole clock; all logic on rising edge.
REQ-006 RESET_N  in  1  synchronous, active-low reset.
REQ-007 REQ_VALID  in  1  request strobe; qualifies REQ_OP, REQ_SEL, REQ_DIR and REQ_COUNT.
REQ-008 REQ_READY  out  1  high only in IDLE; a request is accepted on REQ_VALID & REQ_READY.
REQ-009 REQ_OP  in  2  00 MOVE, 01 LOAD; 10 and 11 are reserved.
REQ-010 REQ_SEL  in  1  0 selects the RX DQS line, 1 selects the TX DQS line.
REQ-011 REQ_DIR  in  1  1 increments the tap, 0 decrements it.
REQ-012 REQ_COUNT  in  TAP_W  number of taps to move.
REQ-013 DONE  out  1  one-cycle pulse at request completion.
REQ-014 ERR  out  1  one-cycle pulse coincident with DONE when the request aborted or was illegal.
REQ-015 MOVED  out  TAP_W  taps actually moved by the last request; valid from DONE until the next acceptance.
REQ-016 RX_TAP, TX_TAP  out  TAP_W each  tracked tap position of each line.
REQ-017 DELAY_LINE_SEL, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, DELAY_LINE_MOVE  out  1 each  drive the lane-controller delay-line port.
REQ-018 RX_DELAY_LINE_OUT_OF_RANGE, TX_DELAY_LINE_OUT_OF_RANGE  in  1 each  out-of-range flags from the lane controller.

Function
REQ-019 FSM states: IDLE, SETUP, PULSE, GAP, LOAD, SETTLE, FIN.
REQ-020 On acceptance, REQ_SEL, REQ_DIR and REQ_COUNT are latched; later changes to these inputs have no effect until the next acceptance.
REQ-021 Accepted MOVE with nonzero REQ_COUNT: IDLE->SETUP.
REQ-022 Accepted MOVE with REQ_COUNT=0: IDLE->FIN; no pulses, MOVED=0, ERR=0.
REQ-023 Accepted LOAD: IDLE->LOAD.
REQ-024 Accepted reserved op: IDLE->FIN with ERR=1 and no delay-line activity.
REQ-025 SETUP lasts one cycle: DELAY_LINE_SEL and DELAY_LINE_DIRECTION take the latched values; MOVE=0.
REQ-026 SEL and DIRECTION stay stable from SETUP until the cycle after the last MOVE pulse.
REQ-027 PULSE lasts one cycle: DELAY_LINE_MOVE=1; the selected tap register changes by ±1, saturating at 0 and 2^TAP_W-1; the moved counter increments.
REQ-028 GAP lasts MOVE_GAP-1 cycles, so successive MOVE rising edges are exactly MOVE_GAP cycles apart.
REQ-029 In the last GAP cycle, if the selected line's OUT_OF_RANGE flag is 1, or the tracked tap is saturated in the move direction: FIN with ERR=1.
REQ-030 Otherwise, in the last GAP cycle, if the moved counter equals the latched count: FIN with ERR=0; else return to PULSE.
REQ-031 LOAD lasts one cycle with DELAY_LINE_LOAD=1 and SEL=latched value; the selected tap register is set to INIT_TAP.
REQ-032 SETTLE holds for LOAD_SETTLE cycles, then goes to FIN; MOVED=0.
REQ-033 FIN lasts one cycle: DONE=1, ERR as determined above, MOVED updated; then IDLE.
REQ-034 REQ_READY is 0 in FIN; earliest back-to-back acceptance is the cycle after DONE.
REQ-035 Latency for MOVE count N (no abort): DONE is asserted 2 + N*MOVE_GAP cycles after the acceptance cycle.
REQ-036 Latency for LOAD: DONE is asserted 2 + LOAD_SETTLE cycles after the acceptance cycle.
REQ-037 The OUT_OF_RANGE flag of the unselected line is ignored.

Reset
REQ-038 While RESET_N=0 at a clock edge: state=IDLE; REQ_READY=1; DONE=0; ERR=0; MOVED=0; RX_TAP=TX_TAP=INIT_TAP; all four DELAY_LINE_* outputs=0.
REQ-039 Reset asserted mid-operation abandons the request without a DONE pulse; MOVE deasserts at the same edge.

Structure
REQ-040 A shared package lane_dly_pkg holds the REQ_OP encodings, the FSM state enum and the parameter range limits.
REQ-041 One sub-module, lane_dly_tap_trk, holds the RX and TX tap registers with saturating inc/dec/load.

Verification
REQ-042 MOVE, RX, DIR=1, COUNT=3, MOVE_GAP=4 -> three MOVE pulses 4 cycles apart; DONE at acceptance+14; RX_TAP=4; MOVED=3; ERR=0.
REQ-043 MOVE, TX, DIR=0, COUNT=5, TX_TAP=1 -> one pulse; TX_TAP=0; DONE with ERR=1 and MOVED=1.
REQ-044 MOVE, RX, COUNT=10, RX_OUT_OF_RANGE raised after the second pulse -> abort; MOVED=2; ERR=1; TX_OUT_OF_RANGE toggling has no effect.
REQ-045 LOAD, TX, LOAD_SETTLE=8, TX_TAP=9 -> one LOAD pulse with SEL=1; TX_TAP=1; DONE at acceptance+10.
REQ-046 Reserved op 11, then COUNT=0 MOVE -> each gives DONE 1 cycle after acceptance (ERR=1 then ERR=0); no MOVE or LOAD pulses.
REQ-047 RESET_N low for one cycle during a GAP of COUNT=6 -> no DONE; outputs at reset values next cycle; REQ_READY=1.
